// File: rtl/chunk_read_arbiter.sv
// chunk_read_arbiter: shares one pipelined chunk block RAM between NUM_VTU
// voxel traversal units. A round-robin arbiter grants one read per cycle, the
// grant is registered into the RAM request stage, and a tag pipeline carries
// the requester id alongside the read so the response reaches the right VTU.
//
// Ports:
//   clk_in, rst_in    clock, asynchronous active-low reset
//   req_valid/addr    per-VTU read request and block address
//   req_ready         one-hot grant (combinational), request accepted this cycle
//   cancel_in         per-VTU: drop every in-flight read of that VTU
//   resp_valid        one-hot response strobe; resp_data broadcast to all VTUs
//   ram_addr/ram_read_enable/ram_out   chunk RAM interface
//   busy              any read issued or in flight
//
// Optional build macro CHUNK_ARB_PERF_EN adds saturating perf_grants and
// perf_stall counters.
//
// Timing: grant at edge t -> ram_read_enable during t+1 -> RAM samples at t+1
// -> ram_out valid RAM_LATENCY cycles after that sample -> resp_valid after
// edge t+RAM_LATENCY+2.

module chunk_read_arbiter #(
  parameter int unsigned NUM_VTU     = 4,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_VTU-1:0]              req_valid,
  input  logic [NUM_VTU-1:0][ADDR_W-1:0]  req_addr,
  output logic [NUM_VTU-1:0]              req_ready,
  input  logic [NUM_VTU-1:0]              cancel_in,
  output logic [NUM_VTU-1:0]              resp_valid,
  output logic [DATA_W-1:0]               resp_data,
  output logic [ADDR_W-1:0]               ram_addr,
  output logic                            ram_read_enable,
  input  logic [DATA_W-1:0]               ram_out,
  output logic                            busy
`ifdef CHUNK_ARB_PERF_EN
  ,
  output logic [31:0]                     perf_grants,
  output logic [31:0]                     perf_stall
`endif
);

  localparam int unsigned ID_W = (NUM_VTU > 1) ? $clog2(NUM_VTU) : 1;
  localparam int unsigned NSTG = RAM_LATENCY + 1;

  logic [NUM_VTU-1:0]       eligible;
  logic [ID_W-1:0]          rr_ptr;
  logic [ID_W-1:0]          grant_id;
  logic [ID_W-1:0]          scan_id;
  logic                     grant_any;

  logic                     issue_valid;
  logic [ID_W-1:0]          issue_id;
  logic                     issue_kill;
  logic [NSTG-1:0]          tag_valid;
  logic [NSTG-1:0][ID_W-1:0] tag_id;
  logic [NSTG-1:0]          tag_kill;
  logic [NSTG-1:0]          stage_in_valid;
  logic [NSTG-1:0][ID_W-1:0] stage_in_id;
  logic                     resp_fire;

  // A cancelled requester is never granted in its cancel cycle.
  assign eligible = req_valid & ~cancel_in;

  // Round-robin scan starting just after the last winner.
  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    scan_id   = '0;
    for (int unsigned off = 1; off <= NUM_VTU; off++) begin
      scan_id = ID_W'((32'(rr_ptr) + off) % NUM_VTU);
      if (!grant_any && eligible[scan_id]) begin
        grant_any = 1'b1;
        grant_id  = scan_id;
      end
    end
    if (grant_any) req_ready[grant_id] = 1'b1;
  end

  // Cancel kills any stage whose id matches, as that stage advances.
  assign issue_kill = cancel_in[issue_id];

  for (genvar g = 0; g < NSTG; g++) begin : g_stage
    assign tag_kill[g] = cancel_in[tag_id[g]];
    if (g == 0) begin : g_first
      assign stage_in_valid[g] = issue_valid & ~issue_kill;
      assign stage_in_id[g]    = issue_id;
    end else begin : g_rest
      assign stage_in_valid[g] = tag_valid[g-1] & ~tag_kill[g-1];
      assign stage_in_id[g]    = tag_id[g-1];
    end
  end

  // A response coinciding with a cancel of the same id is suppressed.
  assign resp_fire = tag_valid[NSTG-1] & ~tag_kill[NSTG-1];

  // Issue stage, tag pipeline, response register.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rr_ptr          <= ID_W'(NUM_VTU - 1);
      issue_valid     <= 1'b0;
      issue_id        <= '0;
      tag_valid       <= '0;
      tag_id          <= '0;
      ram_read_enable <= 1'b0;
      ram_addr        <= '0;
      resp_valid      <= '0;
      resp_data       <= '0;
      busy            <= 1'b0;
    end else begin
      if (grant_any) begin
        rr_ptr   <= grant_id;
        ram_addr <= req_addr[grant_id];
      end
      ram_read_enable <= grant_any;
      issue_valid     <= grant_any;
      issue_id        <= grant_id;
      tag_valid       <= stage_in_valid;
      tag_id          <= stage_in_id;
      resp_valid      <= '0;
      if (resp_fire) begin
        resp_valid[tag_id[NSTG-1]] <= 1'b1;
        resp_data                  <= ram_out;
      end
      busy <= issue_valid | (|tag_valid);
    end
  end

`ifdef CHUNK_ARB_PERF_EN
  logic stall_c;
  assign stall_c = |(eligible & ~req_ready);

  // Saturating grant and stall counters.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      perf_grants <= '0;
      perf_stall  <= '0;
    end else begin
      if (grant_any && (perf_grants != 32'hFFFF_FFFF)) perf_grants <= perf_grants + 32'd1;
      if (stall_c && (perf_stall != 32'hFFFF_FFFF))    perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
